// File: rtl/div_pkg.sv
// Shared definitions for the RV32M iterative divide/remainder unit:
// operation codes, FSM states and the signed-overflow dividend.
package div_pkg;

  localparam logic [1:0] OP_DIV  = 2'd0;
  localparam logic [1:0] OP_DIVU = 2'd1;
  localparam logic [1:0] OP_REM  = 2'd2;
  localparam logic [1:0] OP_REMU = 2'd3;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_DIV  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  localparam logic [31:0] DIV_MIN_NEG = 32'h8000_0000;

  function automatic logic op_is_signed(input logic [1:0] op);
    return (op == OP_DIV) || (op == OP_REM);
  endfunction

endpackage

// File: rtl/div_step.sv
// One restoring-division step: shift {rem, quo} left, trial-subtract the
// divisor and keep the difference when it does not go negative.
module div_step #(
  parameter int XLEN = 32
) (
  input  logic [XLEN-1:0] i_rem,
  input  logic [XLEN-1:0] i_quo,
  input  logic [XLEN-1:0] i_divisor,
  output logic [XLEN-1:0] o_rem,
  output logic [XLEN-1:0] o_quo
);

  logic [XLEN:0] w_shift;
  logic [XLEN:0] w_trial;
  logic          w_ge;

  assign w_shift = {i_rem, i_quo[XLEN-1]};
  assign w_trial = w_shift - {1'b0, i_divisor};
  // A set shifted-out MSB already exceeds any divisor, so the trial sign bit
  // is only meaningful when that bit is clear.
  assign w_ge    = w_shift[XLEN] | ~w_trial[XLEN];

  assign o_rem = w_ge ? w_trial[XLEN-1:0] : w_shift[XLEN-1:0];
  assign o_quo = {i_quo[XLEN-2:0], w_ge};

endmodule

// File: rtl/div_unit.sv
// Iterative DIV/DIVU/REM/REMU unit: XLEN restoring steps on magnitudes with
// sign fixup at the end; divide-by-zero and signed overflow finish in one cycle.
module div_unit
  import div_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            start,
  input  logic [1:0]      op,
  input  logic [XLEN-1:0] rs1_val,
  input  logic [XLEN-1:0] rs2_val,
  input  logic [4:0]      rd_in,
  input  logic            kill,
  output logic            ready,
  output logic            wb_we,
  output logic [4:0]      wb_rd,
  output logic [XLEN-1:0] wb_data,
  output logic            done
);

  localparam int CNT_W = $clog2(XLEN) + 1;

  state_t           r_state;
  state_t           w_state_next;
  logic             r_sel_rem;
  logic [4:0]       r_rd;
  logic [XLEN-1:0]  r_rem;
  logic [XLEN-1:0]  r_quo;
  logic [XLEN-1:0]  r_divisor;
  logic [XLEN-1:0]  r_wb_data;
  logic             r_q_neg;
  logic             r_r_neg;
  logic [CNT_W-1:0] r_cnt;

  logic             w_signed;
  logic             w_sign1;
  logic             w_sign2;
  logic [XLEN-1:0]  w_abs1;
  logic [XLEN-1:0]  w_abs2;
  logic             w_div_zero;
  logic             w_ovf;
  logic             w_fast;
  logic [XLEN-1:0]  w_fast_res;
  logic             w_accept;
  logic             w_cnt_last;
  logic             w_last;
  logic [XLEN-1:0]  w_rem_step;
  logic [XLEN-1:0]  w_quo_step;
  logic [XLEN-1:0]  w_quo_fix;
  logic [XLEN-1:0]  w_rem_fix;
  logic [XLEN-1:0]  w_final;

  assign w_signed   = op_is_signed(op);
  assign w_sign1    = w_signed & rs1_val[XLEN-1];
  assign w_sign2    = w_signed & rs2_val[XLEN-1];
  assign w_abs1     = w_sign1 ? -rs1_val : rs1_val;
  assign w_abs2     = w_sign2 ? -rs2_val : rs2_val;

  assign w_div_zero = (rs2_val == '0);
  assign w_ovf      = w_signed && (rs1_val == DIV_MIN_NEG) && (rs2_val == '1);
  assign w_fast     = w_div_zero | w_ovf;
  // Zero divisor takes precedence; the two fast cases never overlap anyway.
  assign w_fast_res = op[1] ? (w_div_zero ? rs1_val : '0)
                            : (w_div_zero ? '1 : DIV_MIN_NEG);

  assign w_accept   = (r_state == S_IDLE) && start;
  assign w_cnt_last = (r_cnt == CNT_W'(XLEN - 1));
  assign w_last     = (r_state == S_DIV) && !kill && w_cnt_last;

  div_step #(
    .XLEN(XLEN)
  ) u_step (
    .i_rem    (r_rem),
    .i_quo    (r_quo),
    .i_divisor(r_divisor),
    .o_rem    (w_rem_step),
    .o_quo    (w_quo_step)
  );

  assign w_quo_fix = r_q_neg ? -w_quo_step : w_quo_step;
  assign w_rem_fix = r_r_neg ? -w_rem_step : w_rem_step;
  assign w_final   = r_sel_rem ? w_rem_fix : w_quo_fix;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE: if (start) w_state_next = w_fast ? S_DONE : S_DIV;
      S_DIV: begin
        if (kill)            w_state_next = S_IDLE;
        else if (w_cnt_last) w_state_next = S_DONE;
      end
      S_DONE:  w_state_next = S_IDLE;
      default: w_state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_sel_rem <= 1'b0;
      r_rd      <= '0;
      r_rem     <= '0;
      r_quo     <= '0;
      r_divisor <= '0;
      r_wb_data <= '0;
      r_q_neg   <= 1'b0;
      r_r_neg   <= 1'b0;
      r_cnt     <= '0;
    end else if (w_accept) begin
      r_sel_rem <= op[1];
      r_rd      <= rd_in;
      r_cnt     <= '0;
      if (w_fast) begin
        r_wb_data <= w_fast_res;
      end else begin
        r_rem     <= '0;
        r_quo     <= w_abs1;
        r_divisor <= w_abs2;
        r_q_neg   <= w_sign1 ^ w_sign2;
        r_r_neg   <= w_sign1;
      end
    end else if ((r_state == S_DIV) && !kill) begin
      r_rem <= w_rem_step;
      r_quo <= w_quo_step;
      r_cnt <= r_cnt + 1'b1;
      if (w_last) r_wb_data <= w_final;
    end
  end

  assign ready   = (r_state == S_IDLE);
  assign done    = (r_state == S_DONE);
  assign wb_we   = done && (r_rd != 5'd0);
  assign wb_rd   = r_rd;
  assign wb_data = r_wb_data;

endmodule

// File: tb/tb_div_unit.sv
// Scoreboard bench for div_unit: directed vectors push expected results and
// completion cycles; a negedge monitor pops and compares on every done pulse.
module tb_div_unit;
  import div_pkg::*;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic [1:0]  op = 2'd0;
  logic [31:0] rs1_val = '0;
  logic [31:0] rs2_val = '0;
  logic [4:0]  rd_in = '0;
  logic        kill = 1'b0;
  logic        ready;
  logic        wb_we;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data;
  logic        done;

  div_unit #(.XLEN(32)) dut (
    .clk(clk), .reset(reset), .start(start), .op(op),
    .rs1_val(rs1_val), .rs2_val(rs2_val), .rd_in(rd_in), .kill(kill),
    .ready(ready), .wb_we(wb_we), .wb_rd(wb_rd), .wb_data(wb_data), .done(done)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [4:0]  rd;
    logic [31:0] data;
    int          cyc;
    string       name;
  } exp_t;

  exp_t        sb[$];
  int          checks = 0;
  int          passes = 0;
  logic [31:0] last_data = '0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  always @(negedge clk) begin : monitor
    exp_t e;
    if (!reset) begin
      if (wb_we && !done) chk("we_without_done", 32'(wb_we), 32'd0);
      if (done) begin
        if (sb.size() == 0) begin
          chk("unexpected_done", 32'(done), 32'd0);
        end else begin
          e = sb.pop_front();
          chk({e.name, "_data"}, wb_data, e.data);
          chk({e.name, "_rd"}, 32'(wb_rd), 32'(e.rd));
          chk({e.name, "_we"}, 32'(wb_we), 32'(e.rd != 5'd0));
          chk({e.name, "_cycle"}, 32'(cyc), 32'(e.cyc));
          $display("txn %s: rd=%0d data=%h we=%0b at cycle %0d", e.name, wb_rd, wb_data, wb_we, cyc);
        end
      end
    end
  end

  task automatic drive(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                       input logic [4:0] rd);
    op = o; rs1_val = a; rs2_val = b; rd_in = rd; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_ready(input string name);
    int n = 0;
    while (!ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!ready) chk({name, "_ready_timeout"}, 32'(ready), 32'd1);
  endtask

  task automatic issue(input string name, input logic [1:0] o, input logic [31:0] a,
                       input logic [31:0] b, input logic [4:0] rd,
                       input logic [31:0] exp, input int lat);
    exp_t e;
    e.rd = rd; e.data = exp; e.cyc = cyc + lat; e.name = name;
    sb.push_back(e);
    last_data = exp;
    drive(o, a, b, rd);
    wait_ready(name);
  endtask

  initial begin
    repeat (2) @(negedge clk);
    chk("reset_ready", 32'(ready), 32'd1);
    chk("reset_done", 32'(done), 32'd0);
    chk("reset_we", 32'(wb_we), 32'd0);
    chk("reset_rd", 32'(wb_rd), 32'd0);
    chk("reset_data", wb_data, 32'd0);
    reset = 1'b0;
    @(negedge clk);

    issue("div_100_7",     OP_DIV,  32'd100,        32'd7,          5'd5,  32'd14,         33);
    issue("rem_m7_2",      OP_REM,  32'hFFFF_FFF9,  32'd2,          5'd6,  32'hFFFF_FFFF,  33);
    issue("divu_max_2",    OP_DIVU, 32'hFFFF_FFFF,  32'd2,          5'd7,  32'h7FFF_FFFF,  33);
    issue("remu_max_10",   OP_REMU, 32'hFFFF_FFFF,  32'd10,         5'd8,  32'd5,          33);
    issue("div_m100_7",    OP_DIV,  32'hFFFF_FF9C,  32'd7,          5'd9,  32'hFFFF_FFF2,  33);
    issue("rem_m100_7",    OP_REM,  32'hFFFF_FF9C,  32'd7,          5'd10, 32'hFFFF_FFFE,  33);
    issue("div_100_m7",    OP_DIV,  32'd100,        32'hFFFF_FFF9,  5'd11, 32'hFFFF_FFF2,  33);
    issue("rem_100_m7",    OP_REM,  32'd100,        32'hFFFF_FFF9,  5'd12, 32'd2,          33);
    issue("div_5_0",       OP_DIV,  32'd5,          32'd0,          5'd13, 32'hFFFF_FFFF,  1);
    issue("rem_5_0",       OP_REM,  32'd5,          32'd0,          5'd14, 32'd5,          1);
    issue("divu_5_0",      OP_DIVU, 32'd5,          32'd0,          5'd15, 32'hFFFF_FFFF,  1);
    issue("div_ovf",       OP_DIV,  32'h8000_0000,  32'hFFFF_FFFF,  5'd16, 32'h8000_0000,  1);
    issue("rem_ovf",       OP_REM,  32'h8000_0000,  32'hFFFF_FFFF,  5'd17, 32'd0,          1);
    issue("divu_min_max",  OP_DIVU, 32'h8000_0000,  32'hFFFF_FFFF,  5'd18, 32'd0,          33);
    issue("remu_min_max",  OP_REMU, 32'h8000_0000,  32'hFFFF_FFFF,  5'd19, 32'h8000_0000,  33);
    issue("div_rd0",       OP_DIV,  32'd20,         32'd4,          5'd0,  32'd5,          33);

    // A start while busy must be ignored; the first operation completes.
    begin
      exp_t e;
      e.rd = 5'd3; e.data = 32'd14; e.cyc = cyc + 33; e.name = "busy_div";
      sb.push_back(e);
      last_data = 32'd14;
      drive(OP_DIV, 32'd100, 32'd7, 5'd3);
      repeat (4) @(negedge clk);
      drive(OP_DIVU, 32'd6, 32'd3, 5'd9);
      wait_ready("busy_div");
    end

    // Kill mid-operation: no completion, result register untouched.
    drive(OP_DIV, 32'd1000, 32'd3, 5'd4);
    repeat (9) @(negedge clk);
    kill = 1'b1;
    @(negedge clk);
    kill = 1'b0;
    chk("kill_ready", 32'(ready), 32'd1);
    chk("kill_hold_data", wb_data, last_data);
    repeat (30) @(negedge clk);
    chk("kill_data_after", wb_data, last_data);

    // Asynchronous reset mid-operation.
    drive(OP_DIV, 32'd50, 32'd5, 5'd6);
    repeat (5) @(negedge clk);
    reset = 1'b1;
    #1;
    chk("areset_ready", 32'(ready), 32'd1);
    chk("areset_done", 32'(done), 32'd0);
    chk("areset_we", 32'(wb_we), 32'd0);
    chk("areset_rd", 32'(wb_rd), 32'd0);
    chk("areset_data", wb_data, 32'd0);
    @(negedge clk);
    reset = 1'b0;
    issue("div_9_3", OP_DIV, 32'd9, 32'd3, 5'd7, 32'd3, 33);

    repeat (3) @(negedge clk);
    chk("scoreboard_empty", 32'(sb.size()), 32'd0);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, checks=%0d", checks);
    $fatal(1, "watchdog");
  end

endmodule
